// File: rtl/dcache_store_port.sv
// dcache_store_port: store-buffer drain port into a direct-mapped, write-back,
// write-allocate data array, with a line-wide miss port and a combinational load probe.
module dcache_store_port #(
    parameter int unsigned WORD_SIZE        = 32,
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned SIZE_WRITE_WIDTH = 2,
    parameter int unsigned LINES            = 4,
    parameter int unsigned LINE_BYTES       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cache_wenable,
    input  logic [WIDTH-1:0]            cache_physical_address,
    input  logic [WORD_SIZE-1:0]        cache_store_value,
    input  logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
    output logic                        store_ack,
    output logic                        store_error,
    output logic                        busy,
    input  logic [WIDTH-1:0]            load_address,
    output logic                        load_hit,
    output logic [WORD_SIZE-1:0]        load_value,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [WIDTH-1:0]            mem_addr,
    output logic [LINE_BYTES*8-1:0]     mem_wdata,
    input  logic [LINE_BYTES*8-1:0]     mem_rdata,
    input  logic                        mem_ready
);

    localparam int unsigned LW    = LINE_BYTES * 8;
    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = WIDTH - OFF_W - IDX_W;
    localparam int unsigned WB_W  = $clog2(WORD_SIZE / 8);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t state, state_next;

    // Line state and storage
    logic [LINES-1:0]       valid, dirty;
    logic [TAG_W-1:0]       tag_arr  [LINES];
    logic [LW-1:0]          data_arr [LINES];

    // Line address ({tag, idx}) of the store that missed
    logic [TAG_W+IDX_W-1:0] miss_line, miss_line_next;
    logic [IDX_W-1:0]       miss_idx;
    logic [TAG_W-1:0]       miss_tag;

    // Store address decode
    logic [OFF_W-1:0]       st_off;
    logic [IDX_W-1:0]       st_idx;
    logic [TAG_W-1:0]       st_tag;
    logic [OFF_W+2:0]       st_shamt;
    logic                   st_hit;
    logic                   st_illegal;
    logic [WORD_SIZE-1:0]   st_mask;
    logic [LW-1:0]          st_bits;
    logic [LW-1:0]          st_data;
    logic [LW-1:0]          st_merged;

    // Array write strobes from the FSM
    logic                   hit_write;
    logic                   fill_done;

    // Load probe decode
    logic [IDX_W-1:0]       ld_idx;
    logic [TAG_W-1:0]       ld_tag;
    logic [OFF_W+2:0]       ld_shamt;
    logic                   unused_load_lsbs;

    assign st_off   = cache_physical_address[OFF_W-1:0];
    assign st_idx   = cache_physical_address[OFF_W +: IDX_W];
    assign st_tag   = cache_physical_address[WIDTH-1 -: TAG_W];
    assign st_shamt = {st_off, 3'b000};
    assign st_hit   = valid[st_idx] && (tag_arr[st_idx] == st_tag);

    assign miss_idx = miss_line[IDX_W-1:0];
    assign miss_tag = miss_line[TAG_W+IDX_W-1 -: TAG_W];

    assign busy = (state != IDLE);

    // Size decode: lane mask for the store and alignment legality
    always_comb begin
        st_illegal = 1'b0;
        st_mask    = '0;
        case (cache_store_size)
            SIZE_WRITE_WIDTH'(0): st_mask = WORD_SIZE'(8'hFF);
            SIZE_WRITE_WIDTH'(1): begin
                st_mask    = WORD_SIZE'(16'hFFFF);
                st_illegal = cache_physical_address[0];
            end
            SIZE_WRITE_WIDTH'(2): begin
                st_mask    = '1;
                st_illegal = |cache_physical_address[WB_W-1:0];
            end
            default: st_illegal = 1'b1;
        endcase
    end

    // Little-endian byte-lane merge of the store into the addressed line
    always_comb begin
        st_bits   = LW'(st_mask) << st_shamt;
        st_data   = LW'(cache_store_value & st_mask) << st_shamt;
        st_merged = (data_arr[st_idx] & ~st_bits) | (st_data & st_bits);
    end

    // Next-state, handshake and memory-port outputs
    always_comb begin
        state_next     = state;
        miss_line_next = miss_line;
        store_ack      = 1'b0;
        store_error    = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        hit_write      = 1'b0;
        fill_done      = 1'b0;
        case (state)
            IDLE: begin
                if (cache_wenable) begin
                    if (st_illegal) begin
                        store_ack   = 1'b1;
                        store_error = 1'b1;
                    end else if (st_hit) begin
                        store_ack = 1'b1;
                        hit_write = 1'b1;
                    end else begin
                        miss_line_next = {st_tag, st_idx};
                        state_next     = (valid[st_idx] && dirty[st_idx]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_arr[miss_idx], miss_idx, {OFF_W{1'b0}}};
                mem_wdata = data_arr[miss_idx];
                if (mem_ready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_line, {OFF_W{1'b0}}};
                if (mem_ready) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, miss line address and per-line valid/dirty bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            miss_line <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            state     <= state_next;
            miss_line <= miss_line_next;
            if (fill_done) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end else if (hit_write) begin
                dirty[st_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are meaningless until the line is valid
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[miss_idx] <= mem_rdata;
            tag_arr[miss_idx]  <= miss_tag;
        end else if (hit_write) begin
            data_arr[st_idx] <= st_merged;
        end
    end

    // Load probe reads the array as of the last edge; same-cycle stores are not forwarded
    assign ld_idx           = load_address[OFF_W +: IDX_W];
    assign ld_tag           = load_address[WIDTH-1 -: TAG_W];
    assign ld_shamt         = {load_address[OFF_W-1:WB_W], {(WB_W+3){1'b0}}};
    assign load_hit         = valid[ld_idx] && (tag_arr[ld_idx] == ld_tag);
    assign load_value       = load_hit ? WORD_SIZE'(data_arr[ld_idx] >> ld_shamt) : '0;
    assign unused_load_lsbs = ^load_address[WB_W-1:0];

endmodule

// File: tb/tb_dcache_store_port.sv
// Bench for dcache_store_port: directed stores with a scoreboard of expected
// store acks and memory transactions, plus direct load-probe checks.
module tb_dcache_store_port;

    logic         clk = 1'b0;
    logic         rst;
    logic         cache_wenable;
    logic [31:0]  cache_physical_address;
    logic [31:0]  cache_store_value;
    logic [1:0]   cache_store_size;
    logic         store_ack;
    logic         store_error;
    logic         busy;
    logic [31:0]  load_address;
    logic         load_hit;
    logic [31:0]  load_value;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_mem;
        bit           err;
        bit           we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        bit           chk_wdata;
    } exp_t;

    exp_t sb[$];

    bit           resp_en = 1'b0;
    bit           ready_pulse_req = 1'b0;
    int           wait_cnt = 0;
    logic [127:0] fill_data = '0;

    dcache_store_port #(
        .WORD_SIZE(32),
        .WIDTH(32),
        .SIZE_WRITE_WIDTH(2),
        .LINES(4),
        .LINE_BYTES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cache_wenable(cache_wenable),
        .cache_physical_address(cache_physical_address),
        .cache_store_value(cache_store_value),
        .cache_store_size(cache_store_size),
        .store_ack(store_ack),
        .store_error(store_error),
        .busy(busy),
        .load_address(load_address),
        .load_hit(load_hit),
        .load_value(load_value),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void exp_ack(input bit err);
        exp_t e;
        e.is_mem = 1'b0; e.err = err; e.we = 1'b0;
        e.addr = '0; e.wdata = '0; e.chk_wdata = 1'b0;
        sb.push_back(e);
    endfunction

    function automatic void exp_mem(input bit we, input logic [31:0] addr,
                                    input logic [127:0] wdata, input bit chk);
        exp_t e;
        e.is_mem = 1'b1; e.err = 1'b0; e.we = we;
        e.addr = addr; e.wdata = wdata; e.chk_wdata = chk;
        sb.push_back(e);
    endfunction

    // Memory responder: completes a request two cycles after it is seen
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_ready) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end else if (ready_pulse_req) begin
                mem_ready       = 1'b1;
                ready_pulse_req = 1'b0;
            end else if (mem_req && resp_en) begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    mem_rdata = fill_data;
                    mem_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and every completed memory transfer
    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst) begin
            if (store_ack) begin
                check("ack_in_idle", busy, 1'b0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack err=%0b expected none", store_error);
                end else begin
                    x = sb.pop_front();
                    check("ack_kind", x.is_mem, 1'b0);
                    check("store_error", store_error, x.err);
                end
            end
            if (mem_req && mem_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem: got mem addr=%0h expected none", mem_addr);
                end else begin
                    x = sb.pop_front();
                    check("mem_kind", x.is_mem, 1'b1);
                    check("mem_we", mem_we, x.we);
                    check("mem_addr", mem_addr, x.addr);
                    if (x.chk_wdata) check("mem_wdata", mem_wdata, x.wdata);
                end
            end
        end
    end

    // Hold a store until acked (bounded); returns cycles spent
    task automatic do_store(input logic [31:0] a, input logic [31:0] v,
                            input logic [1:0] sz, output int cyc);
        bit got;
        cache_physical_address = a;
        cache_store_value      = v;
        cache_store_size       = sz;
        cache_wenable          = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (store_ack) got = 1'b1;
            @(posedge clk);
            #1;
        end
        cache_wenable = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: got no ack for %0h expected ack within 50 cycles", a);
        end
    endtask

    task automatic probe(input string name, input logic [31:0] a,
                         input logic hit, input logic [31:0] val);
        load_address = a;
        #1;
        check({name, "_hit"}, load_hit, hit);
        check({name, "_value"}, load_value, val);
    endtask

    initial begin
        int  cyc;
        bit  got;
        rst                    = 1'b0;
        cache_wenable          = 1'b0;
        cache_physical_address = '0;
        cache_store_value      = '0;
        cache_store_size       = '0;
        load_address           = 32'h104;

        repeat (3) @(posedge clk);
        #1;
        check("rst_store_ack", store_ack, 1'b0);
        check("rst_store_error", store_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_load_hit", load_hit, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: cold miss fills 0x100, then the held store hits
        fill_data = '0;
        resp_en   = 1'b1;
        exp_mem(1'b0, 32'h100, '0, 1'b0);
        exp_ack(1'b0);
        do_store(32'h104, 32'hDEADBEEF, 2'd2, cyc);
        check("cold_miss_cycles", cyc, 4);
        probe("t1_ld104", 32'h104, 1'b1, 32'hDEADBEEF);
        probe("t1_ld100", 32'h100, 1'b1, 32'h0);

        // 2: byte merge on a hit, zero-latency ack
        exp_ack(1'b0);
        do_store(32'h106, 32'h55, 2'd0, cyc);
        check("byte_hit_cycles", cyc, 1);
        probe("t2_ld104", 32'h104, 1'b1, 32'hDE55BEEF);

        // 3: dirty eviction of idx 0 then fill of 0x140
        fill_data = {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
        exp_mem(1'b1, 32'h100, {64'h0, 32'hDE55BEEF, 32'h0}, 1'b1);
        exp_mem(1'b0, 32'h140, '0, 1'b0);
        exp_ack(1'b0);
        do_store(32'h144, 32'h11, 2'd2, cyc);
        check("evict_cycles", cyc, 7);
        probe("t3_ld144", 32'h144, 1'b1, 32'h11);
        probe("t3_ld148", 32'h148, 1'b1, 32'hAAAA0002);
        probe("t3_ld104", 32'h104, 1'b0, 32'h0);

        // 4: illegal sizes/alignments error out at once; legal half on upper lanes
        exp_ack(1'b1);
        do_store(32'h103, 32'hFFFF, 2'd1, cyc);
        check("mis_half_cycles", cyc, 1);
        exp_ack(1'b1);
        do_store(32'h100, 32'h12345678, 2'd3, cyc);
        check("size3_cycles", cyc, 1);
        exp_ack(1'b1);
        do_store(32'h146, 32'hBAD0BAD0, 2'd2, cyc);
        exp_ack(1'b0);
        do_store(32'h14A, 32'h1234BEEF, 2'd1, cyc);
        check("t4_busy", busy, 1'b0);
        probe("t4_ld140", 32'h140, 1'b1, 32'hAAAA0000);
        probe("t4_ld144", 32'h144, 1'b1, 32'h11);
        probe("t4_ld148", 32'h148, 1'b1, 32'hBEEF0002);

        // 5: requests during FILL are ignored until the fill completes
        resp_en   = 1'b0;
        fill_data = {96'h0, 32'hC0FFEE00};
        exp_mem(1'b0, 32'h310, '0, 1'b0);
        exp_ack(1'b0);
        cache_physical_address = 32'h310;
        cache_store_value      = 32'h33333333;
        cache_store_size       = 2'd2;
        cache_wenable          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy", busy, 1'b1);
        check("t5_mem_req", mem_req, 1'b1);
        check("t5_mem_we", mem_we, 1'b0);
        check("t5_mem_addr", mem_addr, 32'h310);
        cache_physical_address = 32'h144;
        cache_store_value      = 32'h77;
        cache_store_size       = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        probe("t5_ld144_during_fill", 32'h144, 1'b1, 32'h11);
        resp_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (store_ack) got = 1'b1;
        end
        @(posedge clk);
        #1;
        cache_wenable = 1'b0;
        check("t5_ack_after_fill", got, 1'b1);
        probe("t5_ld144", 32'h144, 1'b1, 32'h77);
        probe("t5_ld310", 32'h310, 1'b1, 32'hC0FFEE00);
        resp_en         = 1'b0;
        ready_pulse_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_stray_ready_busy", busy, 1'b0);
        check("t5_stray_ready_req", mem_req, 1'b0);
        probe("t5_ld310_after", 32'h310, 1'b1, 32'hC0FFEE00);

        // 6: asynchronous reset in the middle of a fill
        cache_physical_address = 32'h420;
        cache_store_value      = 32'h44;
        cache_store_size       = 2'd2;
        cache_wenable          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_busy", busy, 1'b1);
        check("t6_mem_addr", mem_addr, 32'h420);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_mem_req", mem_req, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ack", store_ack, 1'b0);
        cache_wenable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        probe("t6_ld104", 32'h104, 1'b0, 32'h0);
        probe("t6_ld144", 32'h144, 1'b0, 32'h0);
        probe("t6_ld310", 32'h310, 1'b0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
